// File: rtl/gcd_pkg.sv
// Shared constants for the GCD operand sequencer: default bus width and FSM encoding.
package gcd_pkg;
    localparam int GCD_WIDTH = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_LDA   = 3'd2;
    localparam logic [2:0] ST_LDB   = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_BYP   = 3'd5;
    localparam logic [2:0] ST_RESP  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_LDA   = ST_LDA,
        S_LDB   = ST_LDB,
        S_WAIT  = ST_WAIT,
        S_BYP   = ST_BYP,
        S_RESP  = ST_RESP
    } state_t;
endpackage

// File: rtl/gcd_pair_fifo.sv
// Synchronous FIFO for operand pairs; full/empty derived from pointers carrying one extra wrap bit.
module gcd_pair_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, rptr_q;
    logic         do_push, do_pop;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage is not reset: entries are only visible once the write pointer covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/gcd_operand_sequencer.sv
// Operand sequencer: buffers (A,B) pairs, drives the shared GCD load bus as start/A/B,
// waits for done or a timeout, and returns the result on a valid/ready stream.
module gcd_operand_sequencer
    import gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_WIDTH,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic             out_err,
    output logic             gcd_start,
    output logic [WIDTH-1:0] gcd_data,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_result
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t             state_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [CW-1:0]      cnt_q;
    logic               out_valid_q, out_err_q, gcd_start_q;
    logic [WIDTH-1:0]   out_gcd_q, gcd_data_q;

    logic [2*WIDTH-1:0] fifo_rdata;
    logic               fifo_full, fifo_empty, fifo_pop;
    logic [WIDTH-1:0]   pair_a, pair_b;

    gcd_pair_fifo #(
        .W     (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid),
        .wdata_i ({in_a, in_b}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign pair_a   = fifo_rdata[2*WIDTH-1:WIDTH];
    assign pair_b   = fifo_rdata[WIDTH-1:0];
    assign fifo_pop = (state_q == S_IDLE) && !fifo_empty;
    assign in_ready = !fifo_full;

    assign out_valid = out_valid_q;
    assign out_gcd   = out_gcd_q;
    assign out_err   = out_err_q;
    assign gcd_start = gcd_start_q;
    assign gcd_data  = gcd_data_q;

    // Outputs are registered: each transition loads the values the next state presents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_gcd_q   <= '0;
            out_err_q   <= 1'b0;
            gcd_start_q <= 1'b0;
            gcd_data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (!fifo_empty) begin
                    a_q <= pair_a;
                    b_q <= pair_b;
                    // The subtractive core never terminates on a zero operand.
                    if (pair_a == '0 || pair_b == '0) begin
                        state_q <= S_BYP;
                    end else begin
                        state_q     <= S_ISSUE;
                        gcd_start_q <= 1'b1;
                        gcd_data_q  <= pair_a;
                        cnt_q       <= '0;
                    end
                end
                S_ISSUE: begin
                    gcd_start_q <= 1'b0;
                    gcd_data_q  <= a_q;
                    state_q     <= S_LDA;
                end
                S_LDA: begin
                    gcd_data_q <= b_q;
                    state_q    <= S_LDB;
                end
                S_LDB: begin
                    gcd_data_q <= b_q;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (gcd_done) begin
                        out_gcd_q   <= gcd_result;
                        out_err_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        gcd_data_q  <= '0;
                        state_q     <= S_RESP;
                    end else if (cnt_q == CW'(TIMEOUT)) begin
                        out_gcd_q   <= '0;
                        out_err_q   <= 1'b1;
                        out_valid_q <= 1'b1;
                        gcd_data_q  <= '0;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_BYP: begin
                    out_gcd_q   <= a_q | b_q;
                    out_err_q   <= (a_q == '0) && (b_q == '0);
                    out_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// Bench for gcd_operand_sequencer: a behavioural GCD core stub plus a result scoreboard.
module tb_gcd_operand_sequencer;
    localparam int W   = 16;
    localparam int TMO = 1023;

    typedef struct {
        logic [W-1:0] g;
        logic         e;
        int           cyc;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_gcd;
    logic         out_err;
    logic         gcd_start;
    logic [W-1:0] gcd_data;
    logic         gcd_done;
    logic [W-1:0] gcd_result;

    int   checks = 0, failures = 0, cyc = 0;
    res_t exp_q[$], obs_q[$];
    int   rise_q[$];
    int   starts = 0;
    logic prev_valid = 1'b0;

    gcd_operand_sequencer #(.WIDTH(W), .DEPTH(4), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_gcd(out_gcd), .out_err(out_err), .gcd_start(gcd_start),
        .gcd_data(gcd_data), .gcd_done(gcd_done), .gcd_result(gcd_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] euclid(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x = a, y = b, t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        r.cyc = 0;
        if (a == 0 || b == 0) begin
            r.g = a | b;
            r.e = (a == 0) && (b == 0);
        end else begin
            r.g = euclid(a, b);
            r.e = 1'b0;
        end
        return r;
    endfunction

    // GCD core stub: start, latch A, latch B, then done after core_delay cycles.
    int           core_phase = 0, core_cnt = 0, core_delay = 3;
    bit           never_done = 1'b0;
    logic [W-1:0] core_a, core_b;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_phase <= 0;
            gcd_done   <= 1'b0;
            gcd_result <= '0;
        end else begin
            gcd_done <= 1'b0;
            if (gcd_start) core_phase <= 1;
            else case (core_phase)
                1: begin core_a <= gcd_data; core_phase <= 2; end
                2: begin core_b <= gcd_data; core_phase <= 3; core_cnt <= 0; end
                3: if (!never_done) begin
                    if (core_cnt >= core_delay) begin
                        gcd_done   <= 1'b1;
                        gcd_result <= euclid(core_a, core_b);
                        core_phase <= 0;
                    end else core_cnt <= core_cnt + 1;
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) obs_q.push_back('{g: out_gcd, e: out_err, cyc: cyc});
            if (out_valid && !prev_valid) rise_q.push_back(cyc);
            if (gcd_start) starts++;
        end
        prev_valid = out_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input bit tmo, output int pc);
        int t = 0;
        res_t r;
        while (!in_ready && t < 300) begin step(); t++; end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL push_ready: in_ready=%0b after %0d cycles, required 1", in_ready, t);
            pc = -1;
            return;
        end
        in_valid = 1'b1; in_a = a; in_b = b;
        step();
        in_valid = 1'b0;
        pc = cyc;
        r = model(a, b);
        if (tmo) begin r.g = '0; r.e = 1'b1; end
        exp_q.push_back(r);
    endtask

    task automatic gen(output logic [W-1:0] a, output logic [W-1:0] b);
        int r = $urandom_range(0, 9);
        int g = $urandom_range(1, 40);
        a = W'(g * $urandom_range(1, 200));
        b = W'(g * $urandom_range(1, 200));
        if (r == 0) a = '0;
        if (r == 1) b = '0;
        if (r == 2) begin a = '0; b = '0; end
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        int t = 0;
        while (obs_q.size() < n && t < budget) begin step(); t++; end
        ok = (obs_q.size() >= n);
    endtask

    task automatic test_reset();
        step(); step();
        checks++;
        if ({in_ready, out_valid, out_err, gcd_start} !== 4'b1000 || out_gcd !== 0 || gcd_data !== 0) begin
            failures++;
            $display("FAIL reset_hold: rdy/vld/err/start=%b gcd=%0d data=%0d, required 1000/0/0",
                     {in_ready, out_valid, out_err, gcd_start}, out_gcd, gcd_data);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({in_ready, out_valid, out_err, gcd_start} !== 4'b1000 || out_gcd !== 0 || gcd_data !== 0) begin
            failures++;
            $display("FAIL reset_release: rdy/vld/err/start=%b gcd=%0d data=%0d, required 1000/0/0",
                     {in_ready, out_valid, out_err, gcd_start}, out_gcd, gcd_data);
        end
    endtask

    task automatic test_basic();
        int pc, t = 0, d;
        bit ok;
        logic [W-1:0] seq [4] = '{143, 143, 78, 78};
        core_delay = 4;
        push(143, 78, 0, pc);
        while (!gcd_start && t < 20) begin step(); t++; end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (gcd_data !== seq[i] || gcd_start !== (i == 0)) begin
                failures++;
                $display("FAIL load_seq[%0d]: data=%0d start=%0b, required data=%0d start=%0b",
                         i, gcd_data, gcd_start, seq[i], i == 0);
            end
            step();
        end
        t = 0;
        while (!gcd_done && t < 50) begin step(); t++; end
        d = cyc;
        checks++;
        if (!gcd_done || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL done_seen: done=%0b out_valid=%0b, required 1/0", gcd_done, out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || cyc != d + 1) begin
            failures++;
            $display("FAIL valid_after_done: out_valid=%0b, required 1 one cycle after done", out_valid);
        end
        wait_obs(1, 20, ok);
        checks++;
        if (!ok || obs_q[0].g !== 13 || obs_q[0].e !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: got %0d err=%0b, required 13 err=0",
                     ok ? obs_q[0].g : 'x, ok ? obs_q[0].e : 1'bx);
        end
        obs_q.delete(); exp_q.delete(); rise_q.delete();
    endtask

    task automatic test_bypass();
        int p0, p1, s0;
        bit ok;
        s0 = starts;
        push(0, 42, 0, p0);
        push(0, 0, 0, p1);
        wait_obs(2, 30, ok);
        checks++;
        if (!ok || obs_q[0].g !== 42 || obs_q[0].e !== 1'b0 || obs_q[1].g !== 0 || obs_q[1].e !== 1'b1) begin
            failures++;
            $display("FAIL bypass_results: ok=%0b got %0d/%0b %0d/%0b, required 42/0 0/1", ok,
                     ok ? obs_q[0].g : 'x, ok ? obs_q[0].e : 1'bx, ok ? obs_q[1].g : 'x, ok ? obs_q[1].e : 1'bx);
        end
        checks++;
        if (starts != s0) begin
            failures++;
            $display("FAIL bypass_no_start: starts=%0d, required %0d", starts, s0);
        end
        checks++;
        if (!ok || rise_q.size() < 2 || rise_q[0] - (p0 + 1) > 3 || rise_q[1] - (obs_q[0].cyc + 2) > 3) begin
            failures++;
            $display("FAIL bypass_latency: rises=%0d push=%0d, required out_valid within 3 cycles of pop",
                     rise_q.size(), p0);
        end
        obs_q.delete(); exp_q.delete(); rise_q.delete();
    endtask

    task automatic test_back_to_back();
        int pc, t = 0;
        bit ok;
        logic [W-1:0] a, b;
        core_delay = 40;
        push(91, 35, 0, pc);
        while (core_phase != 3 && t < 20) begin step(); t++; end
        for (int i = 0; i < 4; i++) begin gen(a, b); push(a, b, 0, pc); end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_ready: in_ready=%0b after 4 buffered pairs, required 0", in_ready);
        end
        gen(a, b); push(a, b, 0, pc);
        core_delay = 2;
        wait_obs(6, 600, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL b2b_count: got %0d results, required 6", obs_q.size());
        end
        for (int i = 0; i < 6 && ok; i++) begin
            checks++;
            if (obs_q[i].g !== exp_q[i].g || obs_q[i].e !== exp_q[i].e) begin
                failures++;
                $display("FAIL b2b_result[%0d]: got %0d err=%0b, required %0d err=%0b",
                         i, obs_q[i].g, obs_q[i].e, exp_q[i].g, exp_q[i].e);
            end
        end
        obs_q.delete(); exp_q.delete(); rise_q.delete();
    endtask

    task automatic test_hold();
        int pc, t = 0, s0;
        bit ok;
        logic [W-1:0] g;
        logic e;
        core_delay = 3;
        out_ready = 1'b0;
        push(120, 84, 0, pc);
        push(77, 0, 0, pc);
        while (!out_valid && t < 60) begin step(); t++; end
        g = out_gcd; e = out_err; s0 = starts;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_gcd !== g || out_err !== e || gcd_start !== 1'b0) begin
                failures++;
                $display("FAIL hold[%0d]: vld=%0b gcd=%0d err=%0b start=%0b, required 1/%0d/%0b/0",
                         i, out_valid, out_gcd, out_err, gcd_start, g, e);
            end
        end
        out_ready = 1'b1;
        wait_obs(2, 40, ok);
        checks++;
        if (!ok || starts != s0 || obs_q[0].g !== 12 || obs_q[1].g !== 77 || obs_q[1].e !== 1'b0) begin
            failures++;
            $display("FAIL hold_results: ok=%0b starts=%0d, got %0d %0d, required 12 77",
                     ok, starts - s0, ok ? obs_q[0].g : 'x, ok ? obs_q[1].g : 'x);
        end
        obs_q.delete(); exp_q.delete(); rise_q.delete();
    endtask

    task automatic test_random();
        int pc;
        bit ok, done_push = 1'b0;
        logic [W-1:0] a, b;
        localparam int N = 24;
        fork
            begin
                for (int i = 0; i < N; i++) begin
                    gen(a, b);
                    core_delay = $urandom_range(0, 8);
                    push(a, b, 0, pc);
                    for (int k = $urandom_range(0, 3); k > 0; k--) step();
                end
                done_push = 1'b1;
            end
            begin
                for (int t = 0; t < 4000 && (!done_push || obs_q.size() < N); t++) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_obs(N, 200, ok);
        checks++;
        if (!ok || exp_q.size() != N) begin
            failures++;
            $display("FAIL rand_count: got %0d results for %0d pushes, required %0d", obs_q.size(), exp_q.size(), N);
        end
        for (int i = 0; i < N && ok && exp_q.size() == N; i++) begin
            checks++;
            if (obs_q[i].g !== exp_q[i].g || obs_q[i].e !== exp_q[i].e) begin
                failures++;
                $display("FAIL rand_result[%0d]: got %0d err=%0b, required %0d err=%0b",
                         i, obs_q[i].g, obs_q[i].e, exp_q[i].g, exp_q[i].e);
            end
        end
        obs_q.delete(); exp_q.delete(); rise_q.delete();
    endtask

    task automatic test_timeout();
        int pc, t = 0, w, v;
        bit ok;
        never_done = 1'b1;
        push(10, 4, 1, pc);
        while (core_phase != 3 && t < 20) begin step(); t++; end
        w = cyc;
        t = 0;
        while (!out_valid && t < TMO + 200) begin step(); t++; end
        v = cyc;
        checks++;
        if (!out_valid || v - w != TMO + 1) begin
            failures++;
            $display("FAIL timeout_latency: out_valid=%0b after %0d cycles in WAIT, required %0d",
                     out_valid, v - w, TMO + 1);
        end
        checks++;
        if (out_gcd !== 0 || out_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_value: gcd=%0d err=%0b, required 0 err=1", out_gcd, out_err);
        end
        wait_obs(1, 20, ok);
        never_done = 1'b0;
        obs_q.delete(); exp_q.delete(); rise_q.delete();
    endtask

    task automatic test_reset_mid();
        int pc, t = 0, s0;
        bit ok;
        core_delay = 5;
        push(50, 20, 0, pc);
        push(9, 6, 0, pc);
        while (core_phase != 2 && t < 20) begin step(); t++; end
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, out_err, gcd_start} !== 4'b1000 || out_gcd !== 0 || gcd_data !== 0) begin
            failures++;
            $display("FAIL reset_mid: rdy/vld/err/start=%b gcd=%0d data=%0d, required 1000/0/0",
                     {in_ready, out_valid, out_err, gcd_start}, out_gcd, gcd_data);
        end
        step();
        rst = 1'b0;
        obs_q.delete(); exp_q.delete(); rise_q.delete();
        s0 = starts;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (starts != s0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_fifo_empty: starts=%0d out_valid=%0b in_ready=%0b, required 0/0/1",
                     starts - s0, out_valid, in_ready);
        end
        push(36, 24, 0, pc);
        wait_obs(1, 60, ok);
        checks++;
        if (!ok || obs_q[0].g !== 12 || obs_q[0].e !== 1'b0) begin
            failures++;
            $display("FAIL reset_next_pair: got %0d err=%0b, required 12 err=0",
                     ok ? obs_q[0].g : 'x, ok ? obs_q[0].e : 1'bx);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_back_to_back();
        test_hold();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
